// File: rtl/regfile_sb.sv
// ============================================================================
// regfile_sb: 2R/1W register file with write bypass, pending-write scoreboard
//             with stall generation, and a registered effective-address unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic [$clog2(NREG)-1:0] rs2,
  output logic [XLEN-1:0]         rv1,
  output logic [XLEN-1:0]         rv2,
  input  logic                    rs1_used,
  input  logic                    rs2_used,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic [XLEN-1:0]         wdata,
  input  logic                    iss_we,
  input  logic [$clog2(NREG)-1:0] iss_rd,
  output logic                    stall,
  input  logic                    ea_en,
  input  logic [11:0]             imm,
  output logic [XLEN-1:0]         ea,
  output logic                    ea_valid
);

  localparam int unsigned AW = $clog2(NREG);

  if (NREG < 2 || (NREG & (NREG - 1)) != 0) begin : g_bad_nreg
    $error("regfile_sb: NREG must be a power of two and at least 2");
  end

  function automatic logic writable(input logic [AW-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_eff;
  logic            wr_ok;
  logic            iss_ok;
  logic            byp1;
  logic            byp2;
  logic            busy1;
  logic            busy2;
  logic [XLEN-1:0] imm_sext;

  assign wr_ok    = we && writable(rd);
  assign iss_ok   = iss_we && !stall && writable(iss_rd);
  assign imm_sext = {{(XLEN-12){imm[11]}}, imm};

  // Register 0 can never become pending when it is hard-wired to zero.
  always_comb begin
    pend_eff = pend;
    if (ZERO_REG != 0) pend_eff[0] = 1'b0;
  end

  // Write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[rd] <= wdata;
    end
  end

  // Read ports with same-cycle forwarding of the writeback value
  always_comb begin
    byp1 = (BYPASS != 0) && wr_ok && (rd == rs1);
    byp2 = (BYPASS != 0) && wr_ok && (rd == rs2);
    rv1  = regs[rs1];
    rv2  = regs[rs2];
    if (byp1) rv1 = wdata;
    if (byp2) rv2 = wdata;
    if ((ZERO_REG != 0) && (rs1 == '0)) rv1 = '0;
    if ((ZERO_REG != 0) && (rs2 == '0)) rv2 = '0;
  end

  // A source being written back this cycle is not busy when it can be forwarded.
  always_comb begin
    busy1 = pend_eff[rs1] && !((BYPASS != 0) && we && (rd == rs1));
    busy2 = pend_eff[rs2] && !((BYPASS != 0) && we && (rd == rs2));
    stall = (rs1_used && busy1) || (rs2_used && busy2);
  end

  // Scoreboard: the set is applied after the clear so a new producer wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      if (wr_ok)  pend[rd]     <= 1'b0;
      if (iss_ok) pend[iss_rd] <= 1'b1;
    end
  end

  // Effective address from the forwarded rv1
  always_ff @(posedge clk) begin
    if (reset) begin
      ea       <= '0;
      ea_valid <= 1'b0;
    end else if (ea_en) begin
      ea       <= rv1 + imm_sext;
      ea_valid <= 1'b1;
    end else begin
      ea_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a forwarding instance and a non-forwarding
// instance share all inputs and are compared against an array-based reference model.
`default_nettype none

module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   rs1, rs2, rd, iss_rd;
  logic            rs1_used, rs2_used, we, iss_we, ea_en;
  logic [XLEN-1:0] wdata;
  logic [11:0]     imm;

  logic [XLEN-1:0] rv1_b, rv2_b, ea_b, rv1_n, rv2_n, ea_n;
  logic            stall_b, stall_n, eav_b, eav_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rv1(rv1_b), .rv2(rv2_b),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .we(we), .rd(rd), .wdata(wdata),
    .iss_we(iss_we), .iss_rd(iss_rd), .stall(stall_b), .ea_en(ea_en), .imm(imm),
    .ea(ea_b), .ea_valid(eav_b)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rv1(rv1_n), .rv2(rv2_n),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .we(we), .rd(rd), .wdata(wdata),
    .iss_we(iss_we), .iss_rd(iss_rd), .stall(stall_n), .ea_en(ea_en), .imm(imm),
    .ea(ea_n), .ea_valid(eav_n)
  );

  // Reference model; index 0 = forwarding instance, 1 = non-forwarding instance
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_pend [2][NREG];
  logic [XLEN-1:0] m_ea   [2];
  bit              m_eav  [2];

  function automatic logic [XLEN-1:0] m_read(input int b, input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (b == 0 && we && rd == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic bit m_stall(input int b);
    bit busy1, busy2;
    busy1 = m_pend[b][rs1] && !(b == 0 && we && rd == rs1);
    busy2 = m_pend[b][rs2] && !(b == 0 && we && rd == rs2);
    return (rs1_used && busy1) || (rs2_used && busy2);
  endfunction

  task automatic idle();
    reset = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    we = 0; rd = 0; wdata = 0; iss_we = 0; iss_rd = 0; ea_en = 0; imm = 0;
  endtask

  // Advance the model with the inputs as they stand, then clock the DUTs.
  task automatic tick();
    bit              st [2];
    logic [XLEN-1:0] r1 [2];
    for (int b = 0; b < 2; b++) begin
      st[b] = m_stall(b);
      r1[b] = m_read(b, rs1);
    end
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_pend[0][i] = 0;
        m_pend[1][i] = 0;
      end
      for (int b = 0; b < 2; b++) begin m_ea[b] = '0; m_eav[b] = 0; end
    end else begin
      if (we && rd != 0) m_regs[rd] = wdata;
      for (int b = 0; b < 2; b++) begin
        if (we && rd != 0) m_pend[b][rd] = 0;
        if (iss_we && !st[b] && iss_rd != 0) m_pend[b][iss_rd] = 1;
        if (ea_en) begin
          m_ea[b]  = r1[b] + {{(XLEN-12){imm[11]}}, imm};
          m_eav[b] = 1;
        end else begin
          m_eav[b] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1; tick(); reset = 0;
    for (int a = 0; a < NREG; a++) begin
      rs1 = AW'(a); rs2 = AW'(NREG - 1 - a); #1;
      checks++;
      if (rv1_b !== '0 || rv2_b !== '0 || rv1_n !== '0 || rv2_n !== '0) begin
        failures++;
        $display("FAIL reset_read a=%0d rv1=%h rv2=%h rv1_nb=%h rv2_nb=%h expected 0", a, rv1_b, rv2_b, rv1_n, rv2_n);
      end
    end
    rs1_used = 1; rs2_used = 1; #1;
    checks++;
    if (stall_b !== 1'b0 || stall_n !== 1'b0 || eav_b !== 1'b0 || ea_b !== '0) begin
      failures++;
      $display("FAIL reset_state stall=%b stall_nb=%b ea_valid=%b ea=%h expected 0", stall_b, stall_n, eav_b, ea_b);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    idle(); we = 1; rd = 0; wdata = 32'hDEAD; rs1 = 0; #1;
    checks++;
    if (rv1_b !== '0) begin failures++; $display("FAIL zero_bypass rv1=%h expected 0", rv1_b); end
    tick(); idle(); #1;
    checks++;
    if (rv1_b !== '0 || rv1_n !== '0) begin
      failures++; $display("FAIL zero_write rv1=%h rv1_nb=%h expected 0", rv1_b, rv1_n);
    end
    iss_we = 1; iss_rd = 0; tick(); idle(); rs1 = 0; rs1_used = 1; #1;
    checks++;
    if (stall_b !== 1'b0) begin failures++; $display("FAIL zero_issue stall=%b expected 0", stall_b); end
    idle();
  endtask

  task automatic test_bypass();
    idle(); we = 1; rd = 5; wdata = 32'h1234_5678; rs1 = 5; rs2 = 5; #1;
    checks++;
    if (rv1_b !== 32'h1234_5678 || rv2_b !== 32'h1234_5678) begin
      failures++; $display("FAIL bypass_same_cycle rv1=%h rv2=%h expected 12345678", rv1_b, rv2_b);
    end
    checks++;
    if (rv1_n !== '0) begin failures++; $display("FAIL nobypass_same_cycle rv1=%h expected 0", rv1_n); end
    tick(); we = 0; #1;
    checks++;
    if (rv1_b !== 32'h1234_5678 || rv2_n !== 32'h1234_5678) begin
      failures++; $display("FAIL bypass_next_cycle rv1=%h rv2_nb=%h expected 12345678", rv1_b, rv2_n);
    end
    idle();
  endtask

  task automatic test_scoreboard_stall();
    idle(); iss_we = 1; iss_rd = 7; tick();
    idle(); rs1 = 7; rs1_used = 1; #1;
    checks++;
    if (stall_b !== 1'b1 || stall_n !== 1'b1) begin
      failures++; $display("FAIL stall_c1 stall=%b stall_nb=%b expected 1", stall_b, stall_n);
    end
    tick(); #1;
    checks++;
    if (stall_b !== 1'b1 || stall_n !== 1'b1) begin
      failures++; $display("FAIL stall_c2 stall=%b stall_nb=%b expected 1", stall_b, stall_n);
    end
    tick(); we = 1; rd = 7; wdata = 9; #1;
    checks++;
    if (stall_b !== 1'b0 || rv1_b !== 32'd9) begin
      failures++; $display("FAIL stall_c3_bypass stall=%b rv1=%h expected 0 and 9", stall_b, rv1_b);
    end
    checks++;
    if (stall_n !== 1'b1) begin failures++; $display("FAIL stall_c3_nobypass stall=%b expected 1", stall_n); end
    tick(); we = 0; #1;
    checks++;
    if (stall_n !== 1'b0 || rv1_n !== 32'd9) begin
      failures++; $display("FAIL stall_c4_nobypass stall=%b rv1=%h expected 0 and 9", stall_n, rv1_n);
    end
    idle();
  endtask

  task automatic test_set_wins();
    idle(); iss_we = 1; iss_rd = 3; tick();
    idle(); we = 1; rd = 3; wdata = 32'hAB; iss_we = 1; iss_rd = 3; tick();
    idle(); rs2 = 3; rs2_used = 1; #1;
    checks++;
    if (stall_b !== 1'b1 || stall_n !== 1'b1 || rv2_b !== 32'hAB) begin
      failures++; $display("FAIL set_wins stall=%b stall_nb=%b rv2=%h expected 1 1 ab", stall_b, stall_n, rv2_b);
    end
    idle(); we = 1; rd = 3; wdata = 32'hAB; tick(); idle();
  endtask

  task automatic test_ea();
    idle(); we = 1; rd = 2; wdata = 32'h10; tick();
    idle(); ea_en = 1; rs1 = 2; imm = 12'hFFC; tick();
    checks++;
    if (ea_b !== 32'hC || eav_b !== 1'b1) begin
      failures++; $display("FAIL ea_neg_offset ea=%h valid=%b expected c 1", ea_b, eav_b);
    end
    idle(); tick();
    checks++;
    if (eav_b !== 1'b0 || ea_b !== 32'hC) begin
      failures++; $display("FAIL ea_hold ea=%h valid=%b expected c 0", ea_b, eav_b);
    end
    we = 1; rd = 2; wdata = 32'hFFFF_FFFF; tick();
    idle(); ea_en = 1; rs1 = 2; imm = 12'h001; tick();
    checks++;
    if (ea_b !== '0 || eav_b !== 1'b1) begin
      failures++; $display("FAIL ea_wrap ea=%h valid=%b expected 0 1", ea_b, eav_b);
    end
    idle(); we = 1; rd = 9; wdata = 32'h100; ea_en = 1; rs1 = 9; imm = 12'h7FF; tick();
    checks++;
    if (ea_b !== 32'h8FF || ea_n !== 32'h7FF) begin
      failures++; $display("FAIL ea_bypass ea=%h ea_nb=%h expected 8ff 7ff", ea_b, ea_n);
    end
    idle();
  endtask

  task automatic test_reset_midway();
    idle(); we = 1; rd = 4; wdata = 32'h55; tick();
    idle(); iss_we = 1; iss_rd = 4; ea_en = 1; tick();
    idle(); reset = 1; we = 1; rd = 6; wdata = 32'h66; iss_we = 1; iss_rd = 8; ea_en = 1; tick();
    idle(); rs1 = 4; rs2 = 6; rs1_used = 1; #1;
    checks++;
    if (stall_b !== 1'b0 || stall_n !== 1'b0 || rv1_b !== '0 || rv2_b !== '0 || eav_b !== 1'b0 || ea_b !== '0) begin
      failures++;
      $display("FAIL reset_midway stall=%b stall_nb=%b rv1=%h rv2=%h ea_valid=%b ea=%h expected all 0",
               stall_b, stall_n, rv1_b, rv2_b, eav_b, ea_b);
    end
    rs1 = 8; #1;
    checks++;
    if (stall_b !== 1'b0) begin failures++; $display("FAIL reset_issue_ignored stall=%b expected 0", stall_b); end
    idle(); we = 1; rd = 4; wdata = 32'h77; tick(); idle(); rs1 = 4; rs1_used = 1; #1;
    checks++;
    if (rv1_n !== 32'h77 || stall_n !== 1'b0) begin
      failures++; $display("FAIL post_reset_write rv1=%h stall=%b expected 77 0", rv1_n, stall_n);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset    = ($urandom_range(0, 63) == 0);
      rs1      = AW'($urandom_range(0, 7));
      rs2      = AW'($urandom_range(0, 7));
      rs1_used = $urandom_range(0, 1) == 1;
      rs2_used = $urandom_range(0, 1) == 1;
      we       = $urandom_range(0, 2) != 0;
      rd       = AW'($urandom_range(0, 7));
      wdata    = $urandom;
      iss_we   = $urandom_range(0, 1) == 1;
      iss_rd   = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, NREG - 1)) : AW'($urandom_range(0, 7));
      imm      = 12'($urandom);
      ea_en    = ($urandom_range(0, 1) == 1) && !m_stall(0) && !m_stall(1);
      #1;
      checks++;
      if (rv1_b !== m_read(0, rs1) || rv2_b !== m_read(0, rs2) ||
          rv1_n !== m_read(1, rs1) || rv2_n !== m_read(1, rs2)) begin
        failures++;
        $display("FAIL rand_read n=%0d rv1=%h rv2=%h rv1_nb=%h rv2_nb=%h expected %h %h %h %h", n,
                 rv1_b, rv2_b, rv1_n, rv2_n, m_read(0, rs1), m_read(0, rs2), m_read(1, rs1), m_read(1, rs2));
      end
      checks++;
      if (stall_b !== m_stall(0) || stall_n !== m_stall(1)) begin
        failures++;
        $display("FAIL rand_stall n=%0d stall=%b stall_nb=%b expected %b %b", n, stall_b, stall_n, m_stall(0), m_stall(1));
      end
      tick();
      checks++;
      if (ea_b !== m_ea[0] || eav_b !== m_eav[0] || ea_n !== m_ea[1] || eav_n !== m_eav[1]) begin
        failures++;
        $display("FAIL rand_ea n=%0d ea=%h/%b ea_nb=%h/%b expected %h/%b %h/%b", n,
                 ea_b, eav_b, ea_n, eav_n, m_ea[0], m_eav[0], m_ea[1], m_eav[1]);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard_stall();
    test_set_wins();
    test_ea();
    test_reset_midway();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
